data_sram_like_bridge: RTL and testbench

DATA_SRAM_LIKE_BRIDGE -- requirements
Module: data_sram_like_bridge

---
 rtl/data_sram_like_bridge_pkg.sv | 26 ++
 rtl/data_sram_like_bridge_if.sv | 59 +++++
 rtl/data_sram_like_bridge.sv | 125 ++++++++++++
 tb/tb_data_sram_like_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_like_bridge_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_like_bridge_pkg
// Shared CPU-side definitions for the MEM-stage to sram-like bridge:
//   state_e    - bridge FSM states (IDLE, ADDR, DATA, DONE)
//   SIZE_*     - access size codes carried on mem_size / data_size
//   norm_size  - folds the unused size code 3 onto a word access
// -----------------------------------------------------------------------------
package data_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size code 3 has no meaning downstream; treat it as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces around data_sram_like_bridge.
//
// data_sram_like_bridge_mem_if : pipeline MEM stage <-> bridge
//   master (pipeline) drives mem_en/mem_wen/mem_size/mem_addr/mem_wdata/pipe_stall
//   slave  (bridge)   drives mem_rdata/mem_stall
//
// data_sram_like_bridge_if : bridge <-> cache_module cpu_data_* (sram-like)
//   master (bridge) drives data_req/data_wr/data_size/data_addr/data_wdata
//   slave  (cache)  drives data_rdata/data_addr_ok/data_data_ok
//
// Handshake: on the sram-like side a request is accepted on a rising edge
// where data_req=1 and data_addr_ok=1; the request fields must stay stable
// from the first cycle data_req is high until that edge. The response is a
// single cycle with data_data_ok=1 (data_rdata valid for loads), which only
// ever follows an accepted address. On the pipeline side mem_en is held with
// its fields constant for as long as mem_stall=1.
// -----------------------------------------------------------------------------
interface data_sram_like_bridge_mem_if;
  logic        mem_en;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pipe_stall;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  modport master (
    output mem_en, mem_wen, mem_size, mem_addr, mem_wdata, pipe_stall,
    input  mem_rdata, mem_stall
  );

  modport slave (
    input  mem_en, mem_wen, mem_size, mem_addr, mem_wdata, pipe_stall,
    output mem_rdata, mem_stall
  );
endinterface

interface data_sram_like_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/data_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_like_bridge
// Converts the MEM-stage access request (mem_*) into a single outstanding
// sram-like transaction toward cache_module and freezes the pipeline while
// it is in progress.
//
// Ports:
//   clk     - sole clock, rising edge
//   rst     - synchronous active-high reset
//   mem     - pipeline side (slave modport): request in, rdata/stall out
//   data    - sram-like side (master modport): request out, response in
//   state_o - current FSM state (debug visibility)
//
// A zero-wait slave (addr_ok in the request cycle, data_ok the next cycle)
// completes in two cycles with mem_stall high for only the first.
// -----------------------------------------------------------------------------
module data_sram_like_bridge
  import data_sram_like_bridge_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  data_sram_like_bridge_mem_if.slave    mem,
  data_sram_like_bridge_if.master       data,
  output state_e                        state_o
);

  state_e      state_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        in_idle;
  logic        resp_now;

  assign in_idle  = (state_q == ST_IDLE);
  assign resp_now = (state_q == ST_DATA) && data.data_data_ok;
  assign state_o  = state_q;

  // ---------------------------------------------------------------------------
  // FSM and request/response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mem.mem_en) begin
            // Capture the request so a stalled address phase cannot be
            // disturbed by the pipeline changing mem_* underneath it.
            wr_q    <= mem.mem_wen;
            size_q  <= norm_size(mem.mem_size);
            addr_q  <= mem.mem_addr;
            wdata_q <= mem.mem_wdata;
            state_q <= data.data_addr_ok ? ST_DATA : ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (data.data_addr_ok) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (data.data_data_ok) begin
            // Stores capture too; the pipeline ignores the value.
            rdata_q <= data.data_rdata;
            // If the pipeline is frozen by someone else, mem_en stays high
            // for this same access; park so it is not issued twice.
            state_q <= mem.pipe_stall ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!mem.pipe_stall) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. In IDLE the request is forwarded live so a zero-wait slave can
  // accept it in the same cycle; afterwards the latched copy is presented.
  // ---------------------------------------------------------------------------
  always_comb begin
    data.data_req  = 1'b0;
    mem.mem_stall  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          data.data_req = mem.mem_en;
          mem.mem_stall = mem.mem_en;
        end
        ST_ADDR: begin
          data.data_req = 1'b1;
          mem.mem_stall = 1'b1;
        end
        ST_DATA: begin
          mem.mem_stall = !data.data_data_ok;
        end
        ST_DONE: begin
          mem.mem_stall = 1'b0;
        end
        default: begin
          data.data_req = 1'b0;
          mem.mem_stall = 1'b0;
        end
      endcase
    end
  end

  assign data.data_wr    = in_idle ? mem.mem_wen               : wr_q;
  assign data.data_size  = in_idle ? norm_size(mem.mem_size)   : size_q;
  assign data.data_addr  = in_idle ? mem.mem_addr              : addr_q;
  assign data.data_wdata = in_idle ? mem.mem_wdata             : wdata_q;

  // Load data bypasses the register in the response cycle so the pipeline
  // sees it without an extra stall cycle.
  assign mem.mem_rdata = resp_now ? data.data_rdata : rdata_q;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_sram_like_bridge
// Directed bench for data_sram_like_bridge. A transaction-level model tracks
// whether an access is waiting for address acceptance, waiting for its
// response, or completed while the pipeline is still frozen, and predicts
// every output each cycle. Literal checks pin specific scenario results.
// -----------------------------------------------------------------------------
module tb_data_sram_like_bridge;
  import data_sram_like_bridge_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_sram_like_bridge_mem_if m_if ();
  data_sram_like_bridge_if     s_if ();
  state_e                      state_dbg;

  data_sram_like_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (m_if.slave),
    .data    (s_if.master),
    .state_o (state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;
  int cnt_req = 0;
  int cnt_stall = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction model
  // ---------------------------------------------------------------------------
  bit          awaiting_accept = 1'b0;  // request shown, not yet accepted
  bit          awaiting_resp   = 1'b0;  // accepted, response not yet seen
  bit          parked          = 1'b0;  // finished, pipeline still frozen
  logic        m_wr    = 1'b0;
  logic [1:0]  m_size  = 2'd0;
  logic [31:0] m_addr  = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      awaiting_accept = 1'b0;
      awaiting_resp   = 1'b0;
      parked          = 1'b0;
      m_rdata         = 32'h0;
    end else if (awaiting_resp) begin
      if (s_if.data_data_ok) begin
        m_rdata       = s_if.data_rdata;
        awaiting_resp = 1'b0;
        parked        = m_if.pipe_stall;
      end
    end else if (awaiting_accept) begin
      if (s_if.data_addr_ok) begin
        awaiting_accept = 1'b0;
        awaiting_resp   = 1'b1;
      end
    end else if (parked) begin
      if (!m_if.pipe_stall) parked = 1'b0;
    end else if (m_if.mem_en) begin
      m_wr    = m_if.mem_wen;
      m_size  = (m_if.mem_size == 2'd3) ? 2'd2 : m_if.mem_size;
      m_addr  = m_if.mem_addr;
      m_wdata = m_if.mem_wdata;
      if (s_if.data_addr_ok) awaiting_resp = 1'b1;
      else awaiting_accept = 1'b1;
    end
  end

  // Compare process: outputs are checked mid-cycle, after inputs settle.
  always @(negedge clk) begin
    logic        e_req, e_stall, e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata, e_rdata;
    if (check_en) begin
      e_rdata = (awaiting_resp && s_if.data_data_ok) ? s_if.data_rdata : m_rdata;
      if (awaiting_resp) begin
        e_req = 1'b0; e_stall = !s_if.data_data_ok;
      end else if (awaiting_accept) begin
        e_req = 1'b1; e_stall = 1'b1;
      end else if (parked) begin
        e_req = 1'b0; e_stall = 1'b0;
      end else begin
        e_req = m_if.mem_en; e_stall = m_if.mem_en;
      end
      if (rst) begin
        e_req = 1'b0; e_stall = 1'b0;
      end
      if (awaiting_accept) begin
        e_wr = m_wr; e_size = m_size; e_addr = m_addr; e_wdata = m_wdata;
      end else begin
        e_wr    = m_if.mem_wen;
        e_size  = (m_if.mem_size == 2'd3) ? 2'd2 : m_if.mem_size;
        e_addr  = m_if.mem_addr;
        e_wdata = m_if.mem_wdata;
      end
      chk("data_req", s_if.data_req, e_req);
      chk("mem_stall", m_if.mem_stall, e_stall);
      chk("mem_rdata", m_if.mem_rdata, e_rdata);
      if (e_req) begin
        chk("data_wr", s_if.data_wr, e_wr);
        chk("data_size", s_if.data_size, e_size);
        chk("data_addr", s_if.data_addr, e_addr);
        if (e_wr) chk("data_wdata", s_if.data_wdata, e_wdata);
      end
      if (!rst) begin
        cnt_req   += int'(s_if.data_req);
        cnt_stall += int'(m_if.mem_stall);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic en, input logic wen, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input logic ps,
                      input logic aok, input logic dok, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst               = r;
    m_if.mem_en       = en;
    m_if.mem_wen      = wen;
    m_if.mem_size     = sz;
    m_if.mem_addr     = a;
    m_if.mem_wdata    = wd;
    m_if.pipe_stall   = ps;
    s_if.data_addr_ok = aok;
    s_if.data_data_ok = dok;
    s_if.data_rdata   = rd;
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Runs just after the negedge compare so counts restart cleanly.
  task automatic clear_counts();
    #1;
    cnt_req   = 0;
    cnt_stall = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_en = 1'b1;
    idle_step();
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("reset_rdata", m_if.mem_rdata, 32'h0);
    chk("reset_req", s_if.data_req, 32'h0);

    // Zero-wait load
    clear_counts();
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("zw_req", s_if.data_req, 32'h1);
    chk("zw_stall", m_if.mem_stall, 32'h1);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("zw_state_data", 32'(state_dbg), 32'(ST_DATA));
    chk("zw_rdata_bypass", m_if.mem_rdata, 32'hDEAD_BEEF);
    idle_step();
    chk("zw_rdata_held", m_if.mem_rdata, 32'hDEAD_BEEF);
    chk("zw_req_cycles", cnt_req, 32'd1);
    chk("zw_stall_cycles", cnt_stall, 32'd1);

    // Delayed addr_ok, pipeline address changes meanwhile; stray data_ok ignored
    clear_counts();
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wait_addr_hold1", s_if.data_addr, 32'h8000_0010);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
    chk("wait_addr_hold2", s_if.data_addr, 32'h8000_0010);
    chk("wait_stray_dok", m_if.mem_rdata, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wait_addr_hold3", s_if.data_addr, 32'h8000_0010);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    idle_step();
    chk("wait_rdata", m_if.mem_rdata, 32'h1234_5678);
    chk("wait_stall_cycles", cnt_stall, 32'd4);
    chk("wait_req_cycles", cnt_req, 32'd4);

    // Byte store
    clear_counts();
    step(1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0100, 32'h0000_00AB, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("st_wr", s_if.data_wr, 32'h1);
    chk("st_size", s_if.data_size, 32'h0);
    chk("st_wdata", s_if.data_wdata, 32'h0000_00AB);
    step(1'b0, 1'b1, 1'b1, 2'd0, 32'h0000_0100, 32'h0000_00AB, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
    chk("st_stall_rel", m_if.mem_stall, 32'h0);
    idle_step();
    chk("st_rdata_upd", m_if.mem_rdata, 32'h7777_7777);
    chk("st_req_cycles", cnt_req, 32'd1);

    // Load completes while the pipeline is frozen elsewhere
    clear_counts();
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("done_state", 32'(state_dbg), 32'(ST_DONE));
      chk("done_rdata", m_if.mem_rdata, 32'hCAFE_F00D);
      chk("done_stall", m_if.mem_stall, 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle_step();
    chk("done_exit", 32'(state_dbg), 32'(ST_IDLE));
    chk("done_req_cycles", cnt_req, 32'd1);

    // Reset in DATA abandons the access
    step(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_mid_req", s_if.data_req, 32'h0);
    chk("rst_mid_stall", m_if.mem_stall, 32'h0);
    idle_step();
    chk("rst_mid_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_mid_rdata", m_if.mem_rdata, 32'h0);

    // Size 3 forwarded as word
    step(1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_0044, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("size3", s_if.data_size, 32'h2);
    step(1'b0, 1'b1, 1'b0, 2'd3, 32'h0000_0044, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);

    // Stray data_ok in IDLE with no request
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0099);
    chk("idle_stray_rdata", m_if.mem_rdata, 32'h0BAD_F00D);
    chk("idle_stray_req", s_if.data_req, 32'h0);

    // Back-to-back: half load with one wait cycle, then half store
    step(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0200, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_A5A5);
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0300, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("b2b_addr", s_if.data_addr, 32'h0000_0300);
    chk("b2b_rdata", m_if.mem_rdata, 32'h0000_A5A5);
    step(1'b0, 1'b1, 1'b1, 2'd1, 32'h0000_0300, 32'h0000_BEEF, 1'b0, 1'b0, 1'b1, 32'h0000_0001);
    idle_step();
    idle_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
